// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter
// Three-master Wishbone arbiter in front of a single SDRAM controller port.
// Round-robin grant, one outstanding transaction, per-transaction timeout,
// and a RELEASE state that waits out the slave's multi-cycle ack so a
// stale ack is never credited to the next grant. All outputs are registered.

module sdram_wb_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    // Upstream masters
    input  logic [2:0]  m_cyc_i,
    input  logic [2:0]  m_stb_i,
    input  logic [2:0]  m_we_i,
    input  logic [68:0] m_addr_i,
    input  logic [95:0] m_dat_i,
    output logic [31:0] m_dat_o,
    output logic [2:0]  m_ack_o,
    output logic [2:0]  m_err_o,
    // Downstream SDRAM controller slave
    output logic [22:0] addr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    // Debug
    output logic [1:0]  grant_o
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [2:0]         req_s;
    logic [1:0]         first_s;
    logic [1:0]         second_s;
    logic [1:0]         winner_s;
    logic [22:0]        win_addr_s;
    logic [31:0]        win_dat_s;
    logic               win_we_s;

    // Next master index in round-robin order (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] res;
        case (idx)
            2'd0:    res = 2'd1;
            2'd1:    res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // One-hot strobe for the given master index; index 3 selects nobody.
    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        logic [2:0] res;
        case (idx)
            2'd0:    res = 3'b001;
            2'd1:    res = 3'b010;
            2'd2:    res = 3'b100;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    // Round-robin winner search starting just after the last grant, plus a mux of its request fields.
    always_comb begin
        req_s    = m_cyc_i & m_stb_i;
        first_s  = rr_next(grant_o);
        second_s = rr_next(first_s);
        if (req_s[first_s]) begin
            winner_s = first_s;
        end else if (req_s[second_s]) begin
            winner_s = second_s;
        end else begin
            // Last in line is the previously granted master itself.
            winner_s = grant_o;
        end
        case (winner_s)
            2'd0: begin
                win_addr_s = m_addr_i[22:0];
                win_dat_s  = m_dat_i[31:0];
                win_we_s   = m_we_i[0];
            end
            2'd1: begin
                win_addr_s = m_addr_i[45:23];
                win_dat_s  = m_dat_i[63:32];
                win_we_s   = m_we_i[1];
            end
            default: begin
                win_addr_s = m_addr_i[68:46];
                win_dat_s  = m_dat_i[95:64];
                win_we_s   = m_we_i[2];
            end
        endcase
    end

    // Arbitration FSM: grant, track the downstream transaction, time out, and wait for ack release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            stb_o   <= 1'b0;
            cyc_o   <= 1'b0;
            we_o    <= 1'b0;
            addr_o  <= 23'd0;
            dat_o   <= 32'd0;
            m_dat_o <= 32'd0;
            m_ack_o <= 3'b000;
            m_err_o <= 3'b000;
            grant_o <= 2'd2;
        end else begin
            // Ack/err are single-cycle pulses unless re-asserted below.
            m_ack_o <= 3'b000;
            m_err_o <= 3'b000;
            case (state_r)
                IDLE: begin
                    if (|req_s) begin
                        addr_o  <= win_addr_s;
                        dat_o   <= win_dat_s;
                        we_o    <= win_we_s;
                        grant_o <= winner_s;
                        stb_o   <= 1'b1;
                        cyc_o   <= 1'b1;
                        cnt_r   <= CNT_W'(TIMEOUT_CYC);
                        state_r <= BUSY;
                    end else begin
                        stb_o   <= 1'b0;
                        cyc_o   <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Ack takes priority over an expiring timeout in the same cycle.
                    if (ack_i) begin
                        if (!we_o) begin
                            m_dat_o <= dat_i;
                        end else begin
                            m_dat_o <= m_dat_o;
                        end
                        m_ack_o <= onehot3(grant_o);
                        stb_o   <= 1'b0;
                        cyc_o   <= 1'b0;
                        state_r <= RELEASE;
                    end else if (cnt_r == '0) begin
                        m_err_o <= onehot3(grant_o);
                        stb_o   <= 1'b0;
                        cyc_o   <= 1'b0;
                        state_r <= RELEASE;
                    end else begin
                        cnt_r   <= cnt_r - CNT_W'(1);
                        state_r <= BUSY;
                    end
                end
                RELEASE: begin
                    // Wait for the slave to drop its (possibly long) ack.
                    if (!ack_i) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RELEASE;
                    end
                end
                default: begin
                    stb_o   <= 1'b0;
                    cyc_o   <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
